// File: rtl/periph_interconnect.sv
// Routes one load/store at a time from the LSU to data RAM or a peripheral slot.
// Handshake per slave: registered response, hung-slave timeout, unmapped-address error.
module periph_interconnect #(
  parameter int unsigned N_SLAVES      = 4,
  parameter int unsigned RAM_SIZE      = 256,
  parameter logic [31:0] PERIPH_BASE   = 32'h8000_0000,
  parameter logic [31:0] PERIPH_STRIDE = 32'h0000_0100,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               be_i,
  output logic                     stall_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic [N_SLAVES-1:0]      req_o,
  output logic                     we_o,
  output logic [31:0]              addr_o,
  output logic [31:0]              wdata_o,
  output logic [3:0]               be_o,
  input  logic [N_SLAVES-1:0]      ack_i,
  input  logic [32*N_SLAVES-1:0]   rdata_i
);

  // state | meaning
  // IDLE  | waiting for a master request
  // REQ   | one-cycle request strobe to the selected slave
  // WAIT  | slave has not acked yet; timeout counter running
  // RESP  | one-cycle response pulse to the master
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t              r_state;
  logic [SW-1:0]       r_sel;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [CW-1:0]       r_cnt;
  logic [N_SLAVES-1:0] r_req;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_hit;
  logic [SW-1:0]       w_sel;
  logic [31:0]         w_off;
  logic [31:0]         w_delta;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_ack;
  logic [31:0]         w_slave_rdata;

  // Descending scan so the lowest matching index overrides; RAM is checked last.
  always_comb begin
    w_hit   = 1'b0;
    w_sel   = '0;
    w_off   = '0;
    w_delta = '0;
    for (int k = N_SLAVES - 1; k >= 1; k--) begin
      w_delta = addr_i - PERIPH_BASE - (PERIPH_STRIDE * 32'(k - 1));
      if (w_delta < PERIPH_STRIDE) begin
        w_hit = 1'b1;
        w_sel = SW'(k);
        w_off = w_delta;
      end
    end
    if (addr_i < 32'(RAM_SIZE)) begin
      w_hit = 1'b1;
      w_sel = '0;
      w_off = addr_i;
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  assign w_ack         = ack_i[r_sel];
  assign w_slave_rdata = rdata_i[{r_sel, 5'b0} +: 32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_cnt    <= '0;
      r_req    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_req    <= '0;
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            if (w_hit) begin
              r_sel   <= w_sel;
              r_we    <= we_i;
              r_addr  <= w_off;
              r_wdata <= wdata_i;
              r_be    <= be_i;
              r_cnt   <= '0;
              r_req   <= w_onehot;
              r_state <= REQ;
            end else begin
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
              r_err    <= 1'b1;
              r_state  <= RESP;
            end
          end
        end
        REQ, WAIT: begin
          // An ack in the final counted cycle still beats the timeout.
          if (w_ack) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_we ? 32'h0 : w_slave_rdata;
            r_err    <= 1'b0;
            r_state  <= RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rvalid <= 1'b1;
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= WAIT;
          end
        end
        RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o  = (r_state != IDLE);
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign req_o    = r_req;
  assign we_o     = r_we;
  assign addr_o   = r_addr;
  assign wdata_o  = r_wdata;
  assign be_o     = r_be;

endmodule

// File: tb/tb_periph_interconnect.sv
// Bench for periph_interconnect: scoreboard of expected responses from a small
// decode/latency model, compared as the interconnect produces rvalid.
module tb_periph_interconnect;
  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i, req_i, we_i;
  logic [31:0]   addr_i, wdata_i;
  logic [3:0]    be_i;
  logic          stall_o, rvalid_o, err_o, we_o;
  logic [31:0]   rdata_o, addr_o, wdata_o;
  logic [N-1:0]  req_o, ack_i;
  logic [3:0]    be_o;
  logic [32*N-1:0] rdata_i;

  always #5 clk = ~clk;

  periph_interconnect #(
    .N_SLAVES(N), .RAM_SIZE(256), .PERIPH_BASE(32'h8000_0000),
    .PERIPH_STRIDE(32'h100), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .stall_o(stall_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .be_o(be_o), .ack_i(ack_i), .rdata_i(rdata_i)
  );

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [N-1:0] req;
    logic [31:0] off;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // observations from the last transaction
  int          o_lat, o_req_cycles;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_err, o_we, o_stall_ok, o_side_ok, o_stall_after;
  logic [N-1:0] o_req_or;
  logic [3:0]  o_be;

  function automatic logic [31:0] sdata(input int k);
    case (k)
      0: sdata = 32'hDEAD_BEEF;
      1: sdata = 32'hC3C3_0001;
      2: sdata = 32'hC3C3_0002;
      default: sdata = 32'hC3C3_0003;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic we, input int ack_cyc, input int ack_slv);
    exp_t e;
    logic hit;
    int   sel;
    hit = 1'b0; sel = 0; e.off = '0;
    if (a < 32'd256) begin
      hit = 1'b1; sel = 0; e.off = a;
    end else if (a >= 32'h8000_0000 && a < 32'h8000_0300) begin
      hit = 1'b1; sel = 1 + int'((a - 32'h8000_0000) >> 8); e.off = (a - 32'h8000_0000) & 32'hFF;
    end
    if (!hit) begin
      e.lat = 1; e.rdata = '0; e.err = 1'b1; e.req = '0; e.off = '0;
    end else begin
      e.req = N'(1) << sel;
      if (ack_slv == sel && ack_cyc >= 1 && ack_cyc <= TO) begin
        e.lat = ack_cyc + 1; e.err = 1'b0; e.rdata = we ? 32'h0 : sdata(sel);
      end else begin
        e.lat = TO + 1; e.err = 1'b1; e.rdata = '0;
      end
    end
    return e;
  endfunction

  // Drives one request from an IDLE cycle (entered at posedge+1) and records what comes back.
  task automatic do_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] be, input int ack_cyc, input int ack_slv);
    o_lat = -1; o_req_cycles = 0; o_req_or = '0; o_rdata = 'x; o_err = 1'bx;
    o_stall_ok = 1'b1; o_side_ok = 1'b1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      ack_i = (cyc == ack_cyc) ? (N'(1) << ack_slv) : '0;
      @(negedge clk);
      if (cyc == 1) begin
        o_addr = addr_o; o_wdata = wdata_o; o_be = be_o; o_we = we_o;
      end else if (addr_o !== o_addr || wdata_o !== o_wdata || be_o !== o_be || we_o !== o_we) begin
        o_side_ok = 1'b0;
      end
      o_req_or = o_req_or | req_o;
      if (req_o !== '0) o_req_cycles++;
      if (stall_o !== 1'b1) o_stall_ok = 1'b0;
      if (rvalid_o === 1'b1) begin
        o_lat = cyc; o_rdata = rdata_o; o_err = err_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ack_i = '0;
    @(negedge clk);
    o_stall_after = stall_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0; ack_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall_o, rvalid_o, err_o, we_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {stall_o, rvalid_o, err_o, we_o});
    end
    checks++;
    if ({rdata_o, addr_o, wdata_o, req_o, be_o} !== '0) begin
      errors++; $display("FAIL reset_buses: rdata=%h addr=%h wdata=%h req=%b be=%b want all 0",
                         rdata_o, addr_o, wdata_o, req_o, be_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_zero_wait();
    exp_t e;
    sb.push_back(model(32'h10, 1'b0, 1, 0));
    do_txn(32'h10, 1'b0, 32'h0, 4'hF, 1, 0);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL zw_latency: got %0d want %0d", o_lat, e.lat); end
    checks++; if (o_rdata !== e.rdata) begin errors++; $display("FAIL zw_rdata: got %h want %h", o_rdata, e.rdata); end
    checks++; if (o_err !== e.err) begin errors++; $display("FAIL zw_err: got %b want %b", o_err, e.err); end
    checks++; if (o_req_or !== e.req || o_req_cycles !== 1) begin
      errors++; $display("FAIL zw_req: got %b for %0d cycles want %b for 1", o_req_or, o_req_cycles, e.req); end
    checks++; if (o_addr !== e.off) begin errors++; $display("FAIL zw_addr_o: got %h want %h", o_addr, e.off); end
    checks++; if (o_stall_ok !== 1'b1 || o_stall_after !== 1'b0) begin
      errors++; $display("FAIL zw_stall: busy_ok=%b after=%b want 1 0", o_stall_ok, o_stall_after); end
  endtask

  task automatic test_wait_write();
    exp_t e;
    sb.push_back(model(32'h8000_0104, 1'b1, 4, 2));
    do_txn(32'h8000_0104, 1'b1, 32'h5A, 4'b0001, 4, 2);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL wr_latency: got %0d want %0d", o_lat, e.lat); end
    checks++; if (o_rdata !== e.rdata || o_err !== e.err) begin
      errors++; $display("FAIL wr_resp: got rdata=%h err=%b want %h %b", o_rdata, o_err, e.rdata, e.err); end
    checks++; if (o_req_or !== e.req || o_req_cycles !== 1) begin
      errors++; $display("FAIL wr_req: got %b x%0d want %b x1", o_req_or, o_req_cycles, e.req); end
    checks++; if (o_addr !== e.off || o_wdata !== 32'h5A || o_be !== 4'b0001 || o_we !== 1'b1) begin
      errors++; $display("FAIL wr_sideband: got addr=%h wdata=%h be=%b we=%b want %h 5a 0001 1",
                         o_addr, o_wdata, o_be, o_we, e.off); end
    checks++; if (o_side_ok !== 1'b1) begin errors++; $display("FAIL wr_side_stable: got %b want 1", o_side_ok); end
  endtask

  task automatic test_decode_bounds();
    logic [31:0] addrs [5] = '{32'h100, 32'h8000_0300, 32'hFF, 32'h8000_02FF, 32'h7FFF_FFFF};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(addrs[i], 1'b0, 1, 3));
      do_txn(addrs[i], 1'b0, 32'h0, 4'hF, 1, (addrs[i] < 32'h100) ? 0 : 3);
      e = model(addrs[i], 1'b0, 1, (addrs[i] < 32'h100) ? 0 : 3);
      void'(sb.pop_front());
      checks++;
      if (o_lat !== e.lat || o_err !== e.err || o_rdata !== e.rdata || o_req_or !== e.req) begin
        errors++; $display("FAIL decode_%h: got lat=%0d err=%b rdata=%h req=%b want %0d %b %h %b",
                           addrs[i], o_lat, o_err, o_rdata, o_req_or, e.lat, e.err, e.rdata, e.req);
      end
      if (e.req !== '0) begin
        checks++;
        if (o_addr !== e.off) begin errors++; $display("FAIL decode_off_%h: got %h want %h", addrs[i], o_addr, e.off); end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back(model(32'h8000_0000, 1'b0, 0, 1));
    do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 1);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat || o_err !== e.err || o_rdata !== e.rdata) begin
      errors++; $display("FAIL timeout: got lat=%0d err=%b rdata=%h want %0d %b %h", o_lat, o_err, o_rdata, e.lat, e.err, e.rdata); end
    sb.push_back(model(32'h8000_0000, 1'b0, TO, 1));
    do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, TO, 1);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat || o_err !== e.err || o_rdata !== e.rdata) begin
      errors++; $display("FAIL timeout_last_ack: got lat=%0d err=%b rdata=%h want %0d %b %h", o_lat, o_err, o_rdata, e.lat, e.err, e.rdata); end
    sb.push_back(model(32'h8000_0000, 1'b0, TO - 1, 1));
    do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, TO - 1, 1);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat || o_err !== e.err) begin
      errors++; $display("FAIL timeout_early_ack: got lat=%0d err=%b want %0d %b", o_lat, o_err, e.lat, e.err); end
  endtask

  task automatic test_foreign_ack();
    exp_t e;
    sb.push_back(model(32'h8000_0010, 1'b0, 3, 3));
    do_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 3, 3);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat || o_err !== e.err) begin
      errors++; $display("FAIL foreign_ack: got lat=%0d err=%b want %0d %b", o_lat, o_err, e.lat, e.err); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int rv = 0, reqs = 0, idles = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20; be_i = 4'hF; ack_i = 4'b0001;
    repeat (3) sb.push_back(model(32'h20, 1'b0, 1, 0));
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (rvalid_o === 1'b1) begin
        rv++;
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_rvalid: got rvalid in cycle %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          checks++; if (rdata_o !== e.rdata || err_o !== e.err) begin
            errors++; $display("FAIL b2b_resp: got %h %b want %h %b", rdata_o, err_o, e.rdata, e.err); end
        end
      end
      if (req_o !== '0) reqs++;
      if (stall_o === 1'b0) idles++;
      @(posedge clk); #1;
    end
    req_i = 1'b0; ack_i = '0;
    checks++; if (rv !== 3 || reqs !== 3 || idles !== 2) begin
      errors++; $display("FAIL b2b_counts: got rvalid=%0d req=%0d idle=%0d want 3 3 2", rv, reqs, idles); end
    sb.delete();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int bad = 0;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8000_0020; wdata_i = 32'h1234; be_i = 4'hF;
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; ack_i = 4'b0010;
    @(negedge clk);
    checks++;
    if ({stall_o, rvalid_o, err_o, we_o, rdata_o, addr_o, wdata_o, req_o, be_o} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: stall=%b rvalid=%b addr=%h wdata=%h want all 0",
                         stall_o, rvalid_o, addr_o, wdata_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid_o !== 1'b0 || stall_o !== 1'b0 || req_o !== '0) bad++;
    end
    @(posedge clk); #1;
    ack_i = '0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_late_ack: got %0d busy cycles want 0", bad); end
    sb.push_back(model(32'h8000_0008, 1'b0, 2, 1));
    do_txn(32'h8000_0008, 1'b0, 32'h0, 4'hF, 2, 1);
    e = sb.pop_front();
    checks++; if (o_lat !== e.lat || o_rdata !== e.rdata || o_err !== e.err || o_addr !== e.off) begin
      errors++; $display("FAIL mid_reset_recover: got lat=%0d rdata=%h err=%b addr=%h want %0d %h %b %h",
                         o_lat, o_rdata, o_err, o_addr, e.lat, e.rdata, e.err, e.off); end
  endtask

  initial begin
    rdata_i = {sdata(3), sdata(2), sdata(1), sdata(0)};
    test_reset();
    test_zero_wait();
    test_wait_write();
    test_decode_bounds();
    test_timeout();
    test_foreign_ack();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/periph_interconnect.md
Name: periph_interconnect

Overview:
Parametrised successor to the data-side address decoder. It routes one core load/store at a time to one of N_SLAVES targets: slave 0 is data RAM, and slaves 1..N_SLAVES-1 are equal-sized peripheral slots (LEDs, switches, UART, ...). Unlike the purely combinational decoder, it runs a request/ack handshake with each slave, registers the response, times out hung slaves and flags unmapped accesses with an error. It sits between the core's LSU and the RAM/peripheral bank.

Parameters:
N_SLAVES, 4, number of targets incl. RAM (>=2)
RAM_SIZE, 256, bytes decoded to slave 0: addresses 0..RAM_SIZE-1
PERIPH_BASE, 32'h80000000, base address of slot 1
PERIPH_STRIDE, 32'h100, bytes per peripheral slot (power of two)
TIMEOUT, 16, max cycles spent in REQ+WAIT before error (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  master request, sampled only in IDLE
we_i  in  1  1 = write, 0 = read
addr_i  in  32  byte address
wdata_i  in  32  write data
be_i  in  4  byte enables
stall_o  out  1  high whenever state != IDLE; master holds its next request
rvalid_o  out  1  one-cycle response pulse (reads and writes)
rdata_o  out  32  read data, valid with rvalid_o; 0 for writes and errors
err_o  out  1  valid with rvalid_o; 1 = unmapped address or timeout
req_o  out  N_SLAVES  one-hot slave request
we_o  out  1  registered we
addr_o  out  32  offset within the selected region (addr_i minus region base)
wdata_o  out  32  registered wdata
be_o  out  4  registered be
ack_i  in  N_SLAVES  slave acknowledge, one bit per slave
rdata_i  in  32*N_SLAVES  slave read data; slave k occupies bits [32k+31:32k]

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; latched selection, address and data cleared.
- Decode (combinational on addr_i in IDLE):
  - addr_i < RAM_SIZE selects slave 0.
  - PERIPH_BASE + (k-1)*PERIPH_STRIDE <= addr_i < PERIPH_BASE + k*PERIPH_STRIDE selects slave k, for k = 1..N_SLAVES-1.
  - If regions overlap, the lowest index wins.
  - Anything else is unmapped.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE with req_i=1 and a mapped address: latch sel, we, offset, wdata, be; go to REQ.
- IDLE with req_i=1 and an unmapped address: go to RESP with err=1 and rdata=0. No slave sees req_o.
- IDLE with req_i=0: stay in IDLE.
- REQ: req_o[sel]=1 for exactly this cycle; we_o/addr_o/wdata_o/be_o are driven from the latches.
  - ack_i[sel]=1 (zero-wait slave): capture rdata_i[sel] (reads only, else 0); go to RESP, err=0.
  - Otherwise go to WAIT.
- WAIT: req_o=0. Sideband outputs stay stable until RESP ends.
  - ack_i[sel]=1: capture data; go to RESP, err=0.
- RESP: rvalid_o=1 and rdata_o/err_o driven from registers for one cycle; then go to IDLE. req_i in the RESP cycle is ignored because stall_o=1.
- Timeout: the counter clears on entry to REQ and increments each REQ/WAIT cycle with no ack.
  - When count reaches TIMEOUT-1 with no ack: go to RESP with err=1 and rdata=0.
  - An ack in that same cycle wins: normal response, err=0.
- ack_i bits of unselected slaves are ignored in every state. ack_i in IDLE/RESP is ignored.
- Latency from the accepting cycle (cycle 0):
  - Zero-wait slave: rvalid at cycle 2.
  - Ack on the n-th WAIT cycle: rvalid at cycle 2+n.
  - Unmapped: rvalid at cycle 1.
  - Timeout: rvalid at cycle TIMEOUT+1.
- Boundaries:
  - addr RAM_SIZE-1 maps to slave 0; addr RAM_SIZE is unmapped (unless a peripheral slot covers it).
  - addr PERIPH_BASE + (N_SLAVES-1)*PERIPH_STRIDE is unmapped.
  - addr_o for slot k = addr_i - PERIPH_BASE - (k-1)*PERIPH_STRIDE, modulo 2^32.
- Reset mid-transaction (any state): next cycle is IDLE with all outputs 0. The pending transaction is dropped with no rvalid, and a late ack is ignored.

Test Plan:
1. Read addr 0x10, slave 0 acks in REQ with rdata_i[31:0]=0xDEADBEEF -> req_o=4'b0001 for 1 cycle, addr_o=0x10; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 at cycle 2; stall_o=1 in cycles 1-2.
2. Write 0x80000104 (slot 2) wdata 0x5A be 4'b0001, slave 2 acks after 3 WAIT cycles -> req_o=4'b0100, addr_o=0x4, wdata_o=0x5A, be_o=0x1; rvalid_o at cycle 5, rdata_o=0, err_o=0.
3. Reads at 0x100 (=RAM_SIZE) and 0x80000300 (N_SLAVES=4) -> req_o stays 0; rvalid_o=1, err_o=1, rdata_o=0 at cycle 1.
4. Read slot 1 (0x80000000), never ack -> rvalid_o=1, err_o=1 at cycle 17 (TIMEOUT=16). Repeat with ack exactly on the last counted cycle -> err_o=0, data returned.
5. Slot 1 access, slave 3 asserts ack_i[3] during WAIT -> ignored, transaction still waiting. Back-to-back requests -> second accepted only after RESP returns to IDLE (stall_o honoured).
6. rst_i=1 during WAIT, then slave acks -> no rvalid_o, all outputs 0, next request handled normally.
